// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared core constants, state encoding and helpers for the block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  localparam int unsigned LIST_W   = 16;  // effective list always covers r0..r15
  localparam int unsigned REG_ID_W = 4;
  localparam int unsigned RD_ID_W  = 5;
  localparam int unsigned CNT_W    = 5;

  localparam logic [REG_ID_W-1:0] SP = 4'd13;
  localparam logic [REG_ID_W-1:0] LR = 4'd14;
  localparam logic [REG_ID_W-1:0] PC = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2
  } seq_state_e;

  // Core-op rd_id encoding: bit 4 clear selects a general register.
  typedef enum logic [RD_ID_W-1:0] {
    RD_GPR  = 5'h00,
    RD_CPSR = 5'h10,
    RD_SPSR = 5'h11
  } rd_code_e;

  // Per-sequence settings captured on the start cycle.
  typedef struct packed {
    logic                op_load;
    logic                wb_en;
    logic                skip_wb;
    logic [REG_ID_W-1:0] base_id;
  } seq_cfg_t;

  function automatic logic [RD_ID_W-1:0] rd_gpr(input logic [REG_ID_W-1:0] r);
    return RD_ID_W'(RD_GPR) | RD_ID_W'(r);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(LIST_W); i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_lsb_pick.sv
// Lowest-set-bit priority encoder with the picked bit cleared from the mask.
module lsb_pick #(
  parameter int unsigned REG_CNT = 8,
  localparam int unsigned IDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic [REG_CNT-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic [REG_CNT-1:0] mask_clr
);

  // Scan from the top so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int i = int'(REG_CNT) - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign mask_clr = mask & (mask - REG_CNT'(1));

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM/PUSH/POP sequencer: walks a register list, one bus word per register.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned REG_CNT = 8,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_load,
  input  logic                dec_before,
  input  logic [REG_CNT-1:0]  reg_list,
  input  logic                extra_reg,
  input  logic [3:0]          base_id,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                wb_en,
  output logic [3:0]          reg_rd_id,
  input  logic [31:0]         reg_rd_data,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [31:0]         bus_wdata,
  input  logic [31:0]         bus_rdata,
  input  logic                bus_ready,
  output logic                rd_en,
  output logic [4:0]          rd_id,
  output logic [31:0]         rd_data,
  output logic                busy,
  output logic                done,
  output logic                branch,
  output logic                err_empty
);

  seq_state_e            state_q, state_d;
  seq_cfg_t              cfg_q;
  logic [LIST_W-1:0]     extra_c, eff_c, mask_q, mask_nxt;
  logic [REG_ID_W-1:0]   cur_reg;
  logic [CNT_W-1:0]      n_c;
  logic [ADDR_W-1:0]     span_c, first_c, wb_val_c, addr_q, wb_val_q;
  logic                  empty_c, accept_c, err_q;

  // Effective list, transfer count and the addresses derived from it.
  assign extra_c  = extra_reg ? (LIST_W'(1) << (op_load ? PC : LR)) : '0;
  assign eff_c    = LIST_W'(reg_list) | extra_c;
  assign n_c      = popcount(eff_c);
  assign span_c   = ADDR_W'({n_c, 2'b00});
  assign first_c  = dec_before ? (base_addr - span_c) : base_addr;
  assign wb_val_c = dec_before ? (base_addr - span_c) : (base_addr + span_c);
  assign empty_c  = (eff_c == '0);
  assign accept_c = (state_q == IDLE) & start & ~empty_c;

  lsb_pick #(.REG_CNT(LIST_W)) u_pick (
    .mask     (mask_q),
    .idx      (cur_reg),
    .mask_clr (mask_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latch the request on accept, then consume one list bit per completed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      mask_q   <= '0;
      addr_q   <= '0;
      wb_val_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) & start & empty_c;
      if (accept_c) begin
        cfg_q    <= '{op_load: op_load, wb_en: wb_en,
                      skip_wb: op_load & eff_c[base_id], base_id: base_id};
        mask_q   <= eff_c;
        addr_q   <= {first_c[ADDR_W-1:2], 2'b00};
        wb_val_q <= wb_val_c;
      end else if ((state_q == XFER) && bus_ready) begin
        mask_q <= mask_nxt;
        addr_q <= addr_q + ADDR_W'(4);
      end
    end
  end

  // Next state and outputs; everything is gated by state so reset forces zeros.
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    reg_rd_id = '0;
    rd_en     = 1'b0;
    rd_id     = '0;
    rd_data   = '0;
    busy      = 1'b0;
    done      = err_q;
    err_empty = err_q;
    branch    = 1'b0;
    case (state_q)
      IDLE: if (accept_c) state_d = XFER;
      XFER: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_wr   = ~cfg_q.op_load;
        bus_addr = addr_q;
        if (!cfg_q.op_load) begin
          reg_rd_id = cur_reg;
          bus_wdata = reg_rd_data;
        end else if (bus_ready) begin
          rd_en   = 1'b1;
          rd_id   = rd_gpr(cur_reg);
          rd_data = bus_rdata;
          branch  = (cur_reg == PC);
        end
        if (bus_ready && (mask_nxt == '0)) state_d = WB;
      end
      WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
        if (cfg_q.wb_en && !cfg_q.skip_wb) begin
          rd_en   = 1'b1;
          rd_id   = rd_gpr(cfg_q.base_id);
          rd_data = wb_val_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a transaction-level reference model.
module tb_ldm_stm_sequencer;
  import ldm_stm_sequencer_pkg::*;

  localparam int unsigned REG_CNT = 8;
  localparam int unsigned ADDR_W  = 32;

  logic               clk, rst_n, start, op_load, dec_before, extra_reg, wb_en;
  logic [REG_CNT-1:0] reg_list;
  logic [3:0]         base_id, reg_rd_id;
  logic [31:0]        base_addr, reg_rd_data, bus_addr, bus_wdata, bus_rdata, rd_data;
  logic               bus_req, bus_wr, bus_ready, rd_en, busy, done, branch, err_empty;
  logic [4:0]         rd_id;

  ldm_stm_sequencer #(.REG_CNT(REG_CNT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_load(op_load), .dec_before(dec_before),
    .reg_list(reg_list), .extra_reg(extra_reg), .base_id(base_id), .base_addr(base_addr),
    .wb_en(wb_en), .reg_rd_id(reg_rd_id), .reg_rd_data(reg_rd_data), .bus_req(bus_req),
    .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data), .busy(busy),
    .done(done), .branch(branch), .err_empty(err_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    return 32'hA5A5_0000 + 32'(r) * 32'h0000_1111;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0001;
  endfunction

  assign reg_rd_data = rf_val(reg_rd_id);
  assign bus_rdata   = mem_val(bus_addr);

  // Reference model state: pending register queue plus phase.
  int          m_phase;   // 0 idle, 1 transferring, 2 writeback
  int          m_q[$];
  logic [31:0] m_addr, m_wbval;
  logic        m_load, m_wb, m_supp, m_err;
  logic [3:0]  m_base;

  int n_checks, n_pass;
  int cyc, done_cyc, busy_cycles, done_cnt, wb_cnt, branch_cnt;
  logic [31:0] wb_data_log;
  int          wb_id_log;
  logic [31:0] st_addr[$];
  int          st_reg[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare DUT outputs against the model for the current cycle, then advance the model.
  task automatic compare_step();
    logic        e_req, e_wr, e_rden, e_busy, e_done, e_br, e_err;
    logic [31:0] e_rdata;
    logic [4:0]  e_rdid;
    logic [15:0] eff;
    int          cur, n;
    if (!rst_n) begin
      check("reset_ctl", 32'({bus_req, bus_wr, rd_en, busy, done, branch, err_empty, reg_rd_id, rd_id}), 32'd0);
      check("reset_addr", bus_addr, 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      check("reset_wdata", bus_wdata, 32'd0);
      m_phase = 0; m_err = 1'b0; m_q.delete();
      return;
    end
    e_req = 0; e_wr = 0; e_rden = 0; e_busy = 0; e_done = 0; e_br = 0; e_err = 0;
    e_rdata = '0; e_rdid = '0; cur = 0;
    if (m_err) begin e_done = 1; e_err = 1; end
    if (m_phase == 1) begin
      cur = m_q[0]; e_req = 1; e_wr = !m_load; e_busy = 1;
      if (bus_ready && m_load) begin
        e_rden = 1; e_rdid = 5'(cur); e_rdata = mem_val(m_addr); e_br = (cur == 15);
      end
    end else if (m_phase == 2) begin
      e_busy = 1; e_done = 1;
      if (m_wb && !m_supp) begin e_rden = 1; e_rdid = {1'b0, m_base}; e_rdata = m_wbval; end
    end
    check("bus_req", 32'(bus_req), 32'(e_req));
    check("bus_wr", 32'(bus_wr), 32'(e_wr));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("err_empty", 32'(err_empty), 32'(e_err));
    check("branch", 32'(branch), 32'(e_br));
    check("rd_en", 32'(rd_en), 32'(e_rden));
    check("addr_align", 32'(bus_addr[1:0]), 32'd0);
    if (e_req) check("bus_addr", bus_addr, m_addr);
    if (e_req && e_wr) begin
      check("reg_rd_id", 32'(reg_rd_id), 32'(cur));
      check("bus_wdata", bus_wdata, rf_val(4'(cur)));
    end
    if (e_rden) begin
      check("rd_id", 32'(rd_id), 32'(e_rdid));
      check("rd_data", rd_data, e_rdata);
    end
    // Observations for the per-scenario literal checks.
    if (busy) busy_cycles++;
    if (branch) branch_cnt++;
    if (done) begin
      done_cyc = cyc; done_cnt++;
      if (rd_en) begin wb_cnt++; wb_id_log = int'(rd_id); wb_data_log = rd_data; end
    end
    if (bus_req && bus_ready && bus_wr) begin
      st_addr.push_back(bus_addr); st_reg.push_back(int'(reg_rd_id));
    end
    cyc++;
    // Advance the model using the inputs the DUT samples at the coming edge.
    m_err = 1'b0;
    if (m_phase == 1) begin
      if (bus_ready) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 32'd4;
        if (m_q.size() == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (start) begin
      eff = 16'(reg_list) | (extra_reg ? (op_load ? 16'h8000 : 16'h4000) : 16'h0000);
      m_q.delete();
      for (int r = 0; r < 16; r++) if (eff[r]) m_q.push_back(r);
      n = m_q.size();
      if (n == 0) m_err = 1'b1;
      else begin
        m_phase = 1;
        m_load  = op_load;
        m_base  = base_id;
        m_wb    = wb_en;
        m_supp  = op_load && eff[base_id];
        m_addr  = dec_before ? base_addr - 32'(4 * n) : base_addr;
        m_wbval = dec_before ? base_addr - 32'(4 * n) : base_addr + 32'(4 * n);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_step();
    @(posedge clk);
    #1;
  endtask

  int s_busy, s_done, s_wb, s_br, s_st, s_cyc;

  // Issue one request; pat[k] is bus_ready in the k-th cycle after start; busy_k re-pulses start.
  task automatic run_op(input logic ld, input logic dec, input logic [7:0] list, input logic ex,
                        input logic [3:0] bid, input logic [31:0] base, input logic wb,
                        input logic [15:0] pat, input int busy_k);
    bit fin;
    s_busy = busy_cycles; s_done = done_cnt; s_wb = wb_cnt; s_br = branch_cnt;
    s_st = st_addr.size(); s_cyc = cyc;
    op_load = ld; dec_before = dec; reg_list = list; extra_reg = ex;
    base_id = bid; base_addr = base; wb_en = wb; start = 1'b1; bus_ready = pat[0];
    tick();
    fin = 0;
    for (int k = 1; k < 60; k++) begin
      if (m_phase == 0 && !m_err) begin fin = 1; break; end
      start      = (k == busy_k);
      op_load    = 1'($urandom);
      dec_before = 1'($urandom);
      reg_list   = 8'($urandom);
      extra_reg  = 1'($urandom);
      base_id    = 4'($urandom);
      base_addr  = $urandom;
      wb_en      = 1'($urandom);
      bus_ready  = (k < 16) ? pat[k] : 1'b1;
      tick();
    end
    start = 1'b0; bus_ready = 1'b1;
    check("op_terminates", 32'(fin), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; done_cyc = 0; busy_cycles = 0; done_cnt = 0;
    wb_cnt = 0; branch_cnt = 0; wb_data_log = '0; wb_id_log = 0;
    m_phase = 0; m_err = 0; m_addr = '0; m_wbval = '0; m_load = 0; m_wb = 0; m_supp = 0; m_base = '0;
    rst_n = 1'b0; start = 0; op_load = 0; dec_before = 0; reg_list = '0; extra_reg = 0;
    base_id = '0; base_addr = '0; wb_en = 0; bus_ready = 1'b1;
    #1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // PUSH {r0,r4,LR} with a start pulse while busy
    run_op(1'b0, 1'b1, 8'h11, 1'b1, SP, 32'h1000, 1'b1, 16'hFFFF, 2);
    check("push_nstores", 32'(st_addr.size() - s_st), 32'd3);
    check("push_addr0", st_addr[s_st], 32'h0000_0FF4);
    check("push_addr1", st_addr[s_st + 1], 32'h0000_0FF8);
    check("push_addr2", st_addr[s_st + 2], 32'h0000_0FFC);
    check("push_reg2", 32'(st_reg[s_st + 2]), 32'd14);
    check("push_wb_id", 32'(wb_id_log), 32'(SP));
    check("push_wb_data", wb_data_log, 32'h0000_0FF4);
    check("push_done_cycle", 32'(done_cyc - s_cyc + 1), 32'd5);
    check("push_busy_cycles", 32'(busy_cycles - s_busy), 32'd4);

    // POP {r1,PC}
    run_op(1'b1, 1'b0, 8'h02, 1'b1, SP, 32'h2000, 1'b1, 16'hFFFF, -1);
    check("pop_branch_cnt", 32'(branch_cnt - s_br), 32'd1);
    check("pop_wb_data", wb_data_log, 32'h0000_2008);
    check("pop_busy_cycles", 32'(busy_cycles - s_busy), 32'd3);

    // LDM r2!,{r2,r3}: base in list, writeback suppressed
    run_op(1'b1, 1'b0, 8'h0C, 1'b0, 4'd2, 32'h3000, 1'b1, 16'hFFFF, -1);
    check("ldm_base_no_wb", 32'(wb_cnt - s_wb), 32'd0);
    check("ldm_done_cnt", 32'(done_cnt - s_done), 32'd1);

    // STM {r0,r1,r3} with a 3-cycle stall on the second transfer
    run_op(1'b0, 1'b0, 8'h0B, 1'b0, 4'd5, 32'h6000, 1'b0, 16'hFFE3, 3);
    check("stall_busy_cycles", 32'(busy_cycles - s_busy), 32'd7);
    check("stall_addr1", st_addr[s_st + 1], 32'h0000_6004);
    check("stall_no_wb", 32'(wb_cnt - s_wb), 32'd0);

    // Empty list
    run_op(1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 32'h8000, 1'b1, 16'hFFFF, -1);
    check("empty_done_cycle", 32'(done_cyc - s_cyc + 1), 32'd2);
    check("empty_done_cnt", 32'(done_cnt - s_done), 32'd1);
    check("empty_busy", 32'(busy_cycles - s_busy), 32'd0);

    // Decrement-before across address zero
    run_op(1'b0, 1'b1, 8'h07, 1'b0, SP, 32'h0000_0004, 1'b1, 16'hFFFF, -1);
    check("wrap_addr0", st_addr[s_st], 32'hFFFF_FFF8);
    check("wrap_addr2", st_addr[s_st + 2], 32'h0000_0000);
    check("wrap_wb_data", wb_data_log, 32'hFFFF_FFF8);

    // Full list plus PC with scattered stalls
    run_op(1'b1, 1'b0, 8'hFF, 1'b1, 4'd11, 32'h7000, 1'b1, 16'hB6DB, -1);
    check("full_wb_data", wb_data_log, 32'h0000_7024);
    check("full_branch_cnt", 32'(branch_cnt - s_br), 32'd1);

    // Reset during the second transfer of a 4-register LDM
    s_done = done_cnt;
    op_load = 1'b1; dec_before = 1'b0; reg_list = 8'h0F; extra_reg = 1'b0;
    base_id = 4'd9; base_addr = 32'h5000; wb_en = 1'b1; start = 1'b1; bus_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_ctl", 32'({bus_req, busy, rd_en, done, branch}), 32'd0);
    check("abort_addr", bus_addr, 32'd0);
    check("abort_rd_data", rd_data, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt - s_done), 32'd0);

    run_op(1'b1, 1'b0, 8'h0F, 1'b0, 4'd9, 32'h5000, 1'b1, 16'hFFFF, -1);
    check("post_rst_wb_data", wb_data_log, 32'h0000_5010);
    check("post_rst_wb_id", 32'(wb_id_log), 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter REG_CNT, default 8, SHALL set the register-list width: 8 for Thumb LDM/STM/PUSH/POP, 16 for ARM block transfers.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address and base-register width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 op_load  in  1  1 = load (LDM/POP), 0 = store (STM/PUSH).
REQ-007 dec_before  in  1  1 = decrement-before (PUSH), 0 = increment-after.
REQ-008 reg_list  in  REG_CNT  register mask; bit i selects register i.
REQ-009 extra_reg  in  1  adds r14 to a store or r15 to a load (PUSH LR / POP PC).
REQ-010 base_id  in  4  base register number.
REQ-011 base_addr  in  ADDR_W  base register value.
REQ-012 wb_en  in  1  base writeback requested.
REQ-013 reg_rd_id  out  4  register-file read select for store data.
REQ-014 reg_rd_data  in  32  register-file read data.
REQ-015 bus_req, bus_wr  out  1 each  transfer request and direction.
REQ-016 bus_addr  out  ADDR_W  word address; bits [1:0] SHALL always be 0.
REQ-017 bus_wdata  out  32; bus_rdata  in  32; bus_ready  in  1  transfer completes in a cycle with bus_req & bus_ready.
REQ-018 rd_en  out  1; rd_id  out  5; rd_data  out  32  register-file write port. rd_id uses the core-op encoding.
REQ-019 busy, done, branch, err_empty  out  1 each  status outputs.

Function
REQ-020 States SHALL be IDLE, XFER and WB.
REQ-021 IDLE -> XFER SHALL occur on start when the effective list is non-empty. The effective list is reg_list plus r14/r15 per extra_reg.
REQ-022 Inputs SHALL be latched on the start cycle, and later changes to them SHALL be ignored.
REQ-023 Count n SHALL be the popcount of the effective list.
REQ-024 The start address SHALL be base_addr when dec_before=0 and base_addr - 4n when dec_before=1, computed modulo 2^ADDR_W.
REQ-025 Registers SHALL transfer in ascending index order at ascending addresses, +4 per transfer, wrapping modulo 2^ADDR_W.
REQ-026 In XFER, bus_req SHALL be held high with stable address, direction and data until bus_ready. On the next cycle the sequencer SHALL advance to the next set bit.
REQ-027 For stores, reg_rd_id SHALL equal the current register and bus_wdata SHALL equal reg_rd_data, combinationally.
REQ-028 For loads, in the cycle bus_ready is high, rd_en=1, rd_id={0,current register} and rd_data=bus_rdata.
REQ-029 A load that writes r15 SHALL pulse branch for that same cycle, and bit 0 SHALL be written as-is.
REQ-030 After the last transfer completes, the sequencer SHALL enter WB for exactly one cycle, then return to IDLE.
REQ-031 In WB, done SHALL pulse. If wb_en=1, rd_en SHALL be 1 with rd_id={0,base_id} and rd_data = base_addr + 4n (increment) or base_addr - 4n (decrement).
REQ-032 A load whose effective list contains base_id SHALL suppress the WB writeback, so the loaded value wins.
REQ-033 busy SHALL be 1 in XFER and WB and 0 in IDLE.
REQ-034 start while busy SHALL be ignored, with no queuing.
REQ-035 An empty effective list SHALL, in the cycle after start, pulse done and err_empty for one cycle with no bus transfer and no writeback. The sequencer SHALL stay in IDLE.
REQ-036 Stalls of any length on bus_ready SHALL be tolerated.

Reset
REQ-037 While rst_n=0, the state SHALL be IDLE and every output SHALL be 0, including bus_addr and rd_data.
REQ-038 Reset asserted mid-transfer SHALL abort the sequence immediately; no writeback or done SHALL follow.
REQ-039 The first start after deassertion SHALL be accepted normally.

Structure
REQ-040 The state encoding, the RD_* special rd_id codes and the register constants SP=13, LR=14, PC=15 SHALL live in the shared core package.
REQ-041 The lowest-set-bit priority encoder plus mask clear SHALL be one sub-module, lsb_pick, parametrised by REG_CNT.
REQ-042 Popcount SHALL be a function in the shared package.

Verification
REQ-043 PUSH {r0,r4,LR}: base_addr=0x1000, dec_before=1, wb_en=1, bus_ready always 1 -> stores r0@0xFF4, r4@0xFF8, r14@0xFFC; WB writes r13=0xFF4; done on cycle 5 after start.
REQ-044 POP {r1,PC}: base_addr=0x2000 -> r1<=mem[0x2000], r15<=mem[0x2004] with branch pulsed; WB writes r13=0x2008.
REQ-045 LDM r2!,{r2,r3}: base_addr=0x3000, wb_en=1 -> r2 and r3 loaded; no writeback to r2 in WB.
REQ-046 STM with bus_ready low for 3 cycles on the second transfer -> bus_addr and bus_wdata held stable; total busy = n+1+3 cycles.
REQ-047 Empty list, extra_reg=0 -> err_empty and done pulse one cycle after start; bus_req never asserted.
REQ-048 rst_n low during the second transfer of a 4-register LDM -> all outputs 0 at once; no done; a new start afterwards completes correctly.
